// File: rtl/forwarding_hazard_unit.sv
// Forwarding and hazard control beside the ID/EX register: tracks in-flight destinations,
// registers the EX operand selects and flag-write enable, and raises load-use / flag stalls.
module forwarding_hazard_unit #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_Rn,
    input  logic [REG_W-1:0] id_Rm,
    input  logic             id_useRn,
    input  logic             id_useRm,
    input  logic [REG_W-1:0] id_Rd,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             id_setFlags,
    input  logic             id_readFlags,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic             enable_EX,
    output logic             stall_IF_ID,
    output logic             bubble_EX,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [REG_W-1:0] ZR      = REG_W'(ZERO_REG);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // EX record is complete; MEM keeps only what forwarding needs. The record leaving MEM
    // is dropped: a WB producer needs no forwarding since the register file writes first.
    logic             ex_valid_q, ex_valid_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             ex_reg_write_q, ex_reg_write_d;
    logic             ex_mem_read_q, ex_mem_read_d;
    logic             ex_set_flags_q, ex_set_flags_d;
    logic             mem_valid_q;
    logic [REG_W-1:0] mem_rd_q;
    logic             mem_reg_write_q;
    logic [1:0]       forward_a_q, forward_a_d;
    logic [1:0]       forward_b_q, forward_b_d;
    logic             enable_ex_q, enable_ex_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic ex_prod_rn, ex_prod_rm, mem_prod_rn, mem_prod_rm;
    logic load_use, flag_hazard, stall;

    always_comb begin
        ex_prod_rn  = ex_valid_q & ex_reg_write_q & (ex_rd_q == id_Rn) & (id_Rn != ZR);
        ex_prod_rm  = ex_valid_q & ex_reg_write_q & (ex_rd_q == id_Rm) & (id_Rm != ZR);
        mem_prod_rn = mem_valid_q & mem_reg_write_q & (mem_rd_q == id_Rn) & (id_Rn != ZR);
        mem_prod_rm = mem_valid_q & mem_reg_write_q & (mem_rd_q == id_Rm) & (id_Rm != ZR);

        load_use    = id_valid & ex_valid_q & ex_mem_read_q & ex_reg_write_q & (ex_rd_q != ZR) &
                      ((id_useRn & (id_Rn == ex_rd_q)) | (id_useRm & (id_Rm == ex_rd_q)));
        flag_hazard = id_valid & id_readFlags & ex_valid_q & ex_set_flags_q;
        stall       = (load_use | flag_hazard) & ~hold;
    end

    always_comb begin
        ex_valid_d     = id_valid;
        ex_rd_d        = id_Rd;
        ex_reg_write_d = id_regWrite;
        ex_mem_read_d  = id_memRead;
        ex_set_flags_d = id_setFlags;
        enable_ex_d    = id_valid & id_setFlags;
        forward_a_d    = 2'd0;
        forward_b_d    = 2'd0;
        stall_count_d  = stall_count_q;

        // Youngest producer wins: EX (moving to MEM) before MEM (moving to WB).
        if (id_useRn & ex_prod_rn)       forward_a_d = 2'd2;
        else if (id_useRn & mem_prod_rn) forward_a_d = 2'd1;
        if (id_useRm & ex_prod_rm)       forward_b_d = 2'd2;
        else if (id_useRm & mem_prod_rm) forward_b_d = 2'd1;

        if (stall) begin
            ex_valid_d     = 1'b0;
            ex_rd_d        = '0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_set_flags_d = 1'b0;
            enable_ex_d    = 1'b0;
            forward_a_d    = 2'd0;
            forward_b_d    = 2'd0;
            if (stall_count_q != '1) stall_count_d = stall_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q      <= 1'b0;
            ex_rd_q         <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_set_flags_q  <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            forward_a_q     <= 2'd0;
            forward_b_q     <= 2'd0;
            enable_ex_q     <= 1'b0;
            stall_count_q   <= '0;
        end else if (!hold) begin
            mem_valid_q     <= ex_valid_q;
            mem_rd_q        <= ex_rd_q;
            mem_reg_write_q <= ex_reg_write_q;
            ex_valid_q      <= ex_valid_d;
            ex_rd_q         <= ex_rd_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_set_flags_q  <= ex_set_flags_d;
            forward_a_q     <= forward_a_d;
            forward_b_q     <= forward_b_d;
            enable_ex_q     <= enable_ex_d;
            stall_count_q   <= stall_count_d;
        end
    end

    assign forwardA    = forward_a_q;
    assign forwardB    = forward_b_q;
    assign enable_EX   = enable_ex_q;
    assign stall_IF_ID = stall;
    assign bubble_EX   = stall;
    assign stall_count = stall_count_q;

endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Control-side partner of the EX stage. Tracks the destination registers of in-flight instructions across EX, MEM and WB.
- Produces registered forwardA/forwardB selects and the EX flag-write enable (enable_EX) for the instruction entering EX.
- Detects load-use and flag-use hazards. On a hazard it stalls IF/ID and injects a bubble into EX.
- Sits beside the ID/EX pipeline register. Its outputs are consumed by the EX stage in the same cycle they become valid.

Parameters:
- REG_W, 5, register index width
- ZERO_REG, 31, hard-wired zero register index (XZR); never forwarded, never a hazard source
- CNT_W, 32, width of stall performance counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- hold  input  1  global pipeline freeze; all internal state holds
- id_valid  input  1  ID holds a real instruction
- id_Rn  input  REG_W  source A index
- id_Rm  input  REG_W  source B index (Rd for stores/CBZ, selected upstream)
- id_useRn  input  1  instruction reads Rn
- id_useRm  input  1  instruction reads Rm
- id_Rd  input  REG_W  destination index
- id_regWrite  input  1  instruction writes Rd
- id_memRead  input  1  instruction is a load
- id_setFlags  input  1  instruction updates NZVC
- id_readFlags  input  1  instruction consumes flags (B.cond)
- forwardA  output  2  EX operand-A select: 0 reg, 1 WB result (Mux_Reg), 2 MEM ALU result (address_MEM)
- forwardB  output  2  same encoding, operand B
- enable_EX  output  1  EX instruction may write flags
- stall_IF_ID  output  1  hold PC and IF/ID register this cycle (combinational)
- bubble_EX  output  1  ID/EX register loads a NOP this cycle (combinational, equals stall_IF_ID)
- stall_count  output  CNT_W  cycles with stall_IF_ID=1, saturating

Behaviour:
- Internal stage records: EX, MEM and WB, each holding {valid, Rd, regWrite, memRead, setFlags}.
- Reset: all record valid bits 0; forwardA=0, forwardB=0, enable_EX=0, stall_count=0.
- Producer definition: a stage is a producer of index r when valid & regWrite & Rd==r & r!=ZERO_REG.
- Load-use hazard:
  - Condition: id_valid & EX.valid & EX.memRead & EX.regWrite & EX.Rd!=ZERO_REG & ((id_useRn & id_Rn==EX.Rd) | (id_useRm & id_Rm==EX.Rd)).
- Flag hazard:
  - Condition: id_valid & id_readFlags & EX.valid & EX.setFlags.
- stall_IF_ID = bubble_EX = (load-use | flag hazard) & !hold. This output is combinational from the current state and inputs.
- Advance (rising clk, hold=0, reset=0):
  - WB <= MEM.
  - MEM <= EX.
  - If stall: EX <= bubble (valid=0), and forwardA/forwardB/enable_EX <= 0.
  - Else: EX <= ID fields, with valid=id_valid.
- forwardA, computed from the ID inputs and registered on advance, for the non-stall case:
  - 2 if id_useRn and the current EX record is a producer of id_Rn (that instruction moves to MEM).
  - Else 1 if id_useRn and the current MEM record is a producer of id_Rn (that instruction moves to WB).
  - Else 0.
  - Priority is 2 over 1: the youngest producer wins.
- forwardB: identical rule using id_useRm and id_Rm.
- Case 2 never selects a load in MEM; the load-use stall guarantees this.
- A WB-stage producer colliding with ID needs no forwarding: the register file writes in the first half-cycle.
- enable_EX <= id_valid & id_setFlags, registered on a non-stall advance.
- hold=1: every register holds, including the outputs and stall_count. stall_IF_ID=0 while hold is asserted.
- stall_count increments on each clock with stall_IF_ID=1 and saturates at all-ones.
- Reset overrides hold and clears a stall mid-operation. The first cycle after reset reports no hazard.
- Back-to-back loads: each dependent instruction stalls exactly one cycle. On the next cycle it receives forward=1 from the load now in WB.

Test Plan:
- Reset with hold=1 -> forwardA=forwardB=0, enable_EX=0, stall_count=0, stall_IF_ID=0.
- ADD X1,X2,X3 then SUB X4,X1,X5 -> on the SUB's EX cycle forwardA=2, forwardB=0; no stall.
- ADD X1; unrelated ORR; AND X6,X7,X1 -> AND in EX gets forwardB=1. The same sequence with X31 as destination -> forwardB=0.
- LDUR X9 then ADD X10,X9,X9 -> one cycle with stall_IF_ID=bubble_EX=1 and stall_count=1; next cycle the ADD enters EX with forwardA=forwardB=1.
- ADDS X1 then B.cond immediately -> one-cycle flag stall; the ADDS has enable_EX=1, the B.cond has enable_EX=0.
- ADD X1 in EX and in MEM (two writers), then a reader of X1 -> forwardA=2 (youngest producer). Asserting hold mid-sequence freezes every output for the held cycles, and the sequence resumes with identical values.
